cpu_core: RTL and testbench
===========================

// Module: cpu_core
// PURPOSE
//   Single-cycle 8-bit accumulator-free register CPU: executes one 32-bit instruction per clk.
//   Owns the PC and an 8x8-bit register file. Instruction memory is external and byte-addressed.
//   The environment drives `instruction` combinationally from {mem[pc+3],mem[pc+2],mem[pc+1],mem[pc]}.
//   Top-level compute block of the teaching processor; later stages add branch/memory ops.
// PARAMETERS
//   DATA_W   8   register/ALU width
//   REG_N    8   number of registers (3-bit addresses)
//   PC_W     32  program counter width
//   PC_STEP  4   bytes per instruction
// PORTS
//   clk          in   1   system clock, all state updates on rising edge
//   rst          in   1   reset, asynchronous, active-low (rst==0 resets)
//   instruction  in   32  current instruction, valid combinationally for current pc
//   pc           out  32  byte address of current instruction
//   Positional port order is fixed: (instruction, clk, rst, pc).
// BEHAVIOUR
//   Encoding: [31:24] opcode, [23:16] dest (bits [18:16] used), [15:8] src1 (bits [10:8]),
//     [7:0] src2 reg (bits [2:0]) or 8-bit immediate. Unused address bits ignored.
//   Opcodes:  0x00 loadi  rd <= imm8
//             0x01 mov    rd <= r[src2]
//             0x02 add    rd <= r[src1] + r[src2]   (mod 256, carry dropped)
//             0x03 sub    rd <= r[src1] + (~r[src2] + 1)  (mod 256)
//             0x04 and    rd <= r[src1] & r[src2]
//             0x05 or     rd <= r[src1] | r[src2]
//             other       no register write (NOP); pc still advances
//   Reset (rst==0, async): pc=0, all registers=0, held while rst low; first fetch at pc=0.
//   Each rising clk with rst==1: pc <= pc + 4 (wraps modulo 2^32) and rd written in the same edge.
//   Latency: result visible in register file immediately after the edge ending the instruction;
//     the next instruction reads it (no hazards, single cycle, no forwarding needed).
//   Register reads: two combinational read ports (src1, src2). Reading and writing the same
//     register in one instruction (e.g. add r1,r1,r1) reads the old value; new value after edge.
//   r0 is an ordinary writable register (not hardwired zero).
//   rst deasserting near a clk edge: pc counts from 0 starting at the first edge with rst==1.
//   X on instruction during reset must not corrupt state (reset dominates).
// STRUCTURE
//   Shared package cpu_pkg: opcode localparams (OP_LOADI..OP_OR), DATA_W, REG_N, PC_STEP.
//   Sub-module reg_file (instance u_reg_file): 8x8 array `regs`, 2 async read, 1 sync write,
//     async active-low clear. ALU + decode + PC logic stay inline in cpu_core.
//   Verification reads registers hierarchically via u_reg_file.regs[i].
// TESTING
//   1 Reset: rst=0 mid-run -> pc=0 and regs all 0 immediately (no clk edge needed).
//   2 Program @0: loadi r0,3; loadi r1,5; add r2,r1,r0; or r7,r3,r2; add r4,r1,r0;
//     and r5,r1,r4 -> after 6 edges r0=3,r1=5,r2=8,r7=8,r4=8,r5=0, pc=24.
//   3 sub: loadi r0,3; loadi r1,5; sub r2,r0,r1 -> r2=0xFE; sub r3,r1,r0 -> r3=2.
//   4 Overflow/mov: loadi r0,0xFF; loadi r1,1; add r2,r0,r1 -> r2=0x00; mov r3,r0 -> r3=0xFF.
//   5 Illegal opcode 0xFF -> no register changes, pc advances by 4.
//   6 PC sequencing: 10 free-running clocks after reset -> pc = 0,4,8,...,40 with no skips.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and instruction layout for the single-cycle 8-bit teaching CPU.
// Opcodes, datapath widths and the packed instruction view live here.
package cpu_pkg;

  localparam int DATA_W  = 8;
  localparam int REG_N   = 8;
  localparam int REG_AW  = $clog2(REG_N);
  localparam int PC_W    = 32;
  localparam int PC_STEP = 4;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] dest;
    logic [7:0] src1;
    logic [7:0] src2;
  } instr_t;

endpackage

// File: rtl/cpu_core_if.sv
// Fetch bus between the core (drives the byte address) and instruction memory
// (returns the 32-bit word at that address combinationally).
interface cpu_core_if;
  import cpu_pkg::*;

  logic [31:0]   instruction;
  logic [PC_W-1:0] pc;

  modport master (input instruction, output pc);
  modport slave  (output instruction, input pc);

endinterface

// File: rtl/cpu_core_reg_file.sv
// 8x8-bit register file: two combinational read ports, one synchronous write port,
// asynchronous active-low clear of every entry.
module reg_file
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr1,
  input  logic [REG_AW-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);

  logic [DATA_W-1:0] regs [REG_N];

  // NOTE: the array is small and architecturally defined as all-zero after
  // reset, so every entry is cleared; larger RAMs would not be reset this way.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (i_we) begin
      regs[i_waddr] <= i_wdata;
    end
  end

  // Reads return the pre-edge value, so an instruction reading its own
  // destination sees the old contents.
  assign o_rdata1 = regs[i_raddr1];
  assign o_rdata2 = regs[i_raddr2];

endmodule

// File: rtl/cpu_core.sv
// Single-cycle CPU: decodes one instruction per clock, executes it in the inline ALU,
// writes the register file and advances the PC by 4 on the same rising edge.
module cpu_core
  import cpu_pkg::*;
(
  input  logic [31:0]     instruction,
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] pc
);

  instr_t            w_instr;
  logic [DATA_W-1:0] w_rdata1;
  logic [DATA_W-1:0] w_rdata2;
  logic [DATA_W-1:0] w_wdata;
  logic              w_we;
  logic              w_unused;
  logic [PC_W-1:0]   r_pc;

  assign w_instr  = instruction;
  assign w_unused = ^{w_instr.dest[7:REG_AW], w_instr.src1[7:REG_AW]};

  reg_file u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_we),
    .i_waddr  (w_instr.dest[REG_AW-1:0]),
    .i_wdata  (w_wdata),
    .i_raddr1 (w_instr.src1[REG_AW-1:0]),
    .i_raddr2 (w_instr.src2[REG_AW-1:0]),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2)
  );

  // NOTE: both outputs get a default before the case, so opcodes that are
  // not decoded leave no path unassigned and no latch is inferred.
  always_comb begin
    w_we    = 1'b0;
    w_wdata = '0;
    unique case (w_instr.opcode)
      OP_LOADI: begin w_we = 1'b1; w_wdata = w_instr.src2;                   end
      OP_MOV:   begin w_we = 1'b1; w_wdata = w_rdata2;                       end
      OP_ADD:   begin w_we = 1'b1; w_wdata = w_rdata1 + w_rdata2;            end
      OP_SUB:   begin w_we = 1'b1; w_wdata = w_rdata1 + (~w_rdata2 + 8'd1); end
      OP_AND:   begin w_we = 1'b1; w_wdata = w_rdata1 & w_rdata2;            end
      OP_OR:    begin w_we = 1'b1; w_wdata = w_rdata1 | w_rdata2;            end
      default:  ;
    endcase
  end

  // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pc <= '0;
    else      r_pc <= r_pc + PC_W'(PC_STEP);
  end

  assign pc = r_pc;

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: byte-addressed instruction memory model feeding the
// fetch bus, hand-computed register/PC expectations checked by immediate assertions.
module tb_cpu_core;
  import cpu_pkg::*;

  logic clk;
  logic rst;
  logic force_x;
  logic [7:0] mem [64];
  int n_checks;
  int n_fail;

  cpu_core_if bus ();

  cpu_core dut (
    .instruction (bus.instruction),
    .clk         (clk),
    .rst         (rst),
    .pc          (bus.pc)
  );

  function automatic logic [5:0] maddr(input logic [31:0] a, input int off);
    logic [31:0] s;
    s = a + 32'(off);
    return s[5:0];
  endfunction

  assign bus.instruction = force_x ? 32'hxxxx_xxxx :
    {mem[maddr(bus.pc, 3)], mem[maddr(bus.pc, 2)], mem[maddr(bus.pc, 1)], mem[maddr(bus.pc, 0)]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reg(input string tag, input int idx, input logic [7:0] exp);
    check($sformatf("%s r%0d", tag, idx), {24'h0, dut.u_reg_file.regs[idx]}, {24'h0, exp});
  endtask

  task automatic put(input int addr, input logic [31:0] ins);
    for (int b = 0; b < 4; b++) mem[addr + b] = ins[8*b +: 8];
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 64; i++) mem[i] = 8'hFF;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic reset_mid_cycle();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    force_x  = 1'b0;
    rst      = 1'b0;
    fill_nop();
    #3;
    check("reset pc", bus.pc, 32'd0);
    for (int i = 0; i < 8; i++) check_reg("reset", i, 8'h00);

    // Program: loads, add, or, add, and.
    put(0,  32'h00_00_00_03);
    put(4,  32'h00_01_00_05);
    put(8,  32'h02_02_01_00);
    put(12, 32'h05_07_03_02);
    put(16, 32'h02_04_01_00);
    put(20, 32'h04_05_01_04);
    release_rst();
    check("pc before first edge", bus.pc, 32'd0);
    step();
    check("pc after 1", bus.pc, 32'd4);
    check_reg("loadi", 0, 8'h03);
    for (int k = 0; k < 5; k++) step();
    check("prog pc", bus.pc, 32'd24);
    check_reg("prog", 0, 8'h03);
    check_reg("prog", 1, 8'h05);
    check_reg("prog", 2, 8'h08);
    check_reg("prog", 7, 8'h08);
    check_reg("prog", 4, 8'h08);
    check_reg("prog", 5, 8'h00);

    // Async reset mid-cycle, then an edge under reset with X on the bus.
    reset_mid_cycle();
    check("async rst pc", bus.pc, 32'd0);
    for (int i = 0; i < 8; i++) check_reg("async rst", i, 8'h00);
    force_x = 1'b1;
    step();
    check("held rst pc", bus.pc, 32'd0);
    check_reg("held rst x", 0, 8'h00);
    check_reg("held rst x", 3, 8'h00);
    force_x = 1'b0;

    // Subtraction, self-referencing add, illegal opcode.
    fill_nop();
    put(0,  32'h00_00_00_03);
    put(4,  32'h00_01_00_05);
    put(8,  32'h03_02_00_01);
    put(12, 32'h03_03_01_00);
    put(16, 32'h02_01_01_01);
    put(20, 32'hFF_00_00_00);
    release_rst();
    for (int k = 0; k < 4; k++) step();
    check_reg("sub neg", 2, 8'hFE);
    check_reg("sub pos", 3, 8'h02);
    step();
    check_reg("add self", 1, 8'h0A);
    check("pc before nop", bus.pc, 32'd20);
    step();
    check("nop pc", bus.pc, 32'd24);
    check_reg("nop", 0, 8'h03);
    check_reg("nop", 1, 8'h0A);
    check_reg("nop", 2, 8'hFE);
    check_reg("nop", 3, 8'h02);

    // Overflow wrap, mov, ignored upper dest bits.
    reset_mid_cycle();
    fill_nop();
    put(0,  32'h00_00_00_FF);
    put(4,  32'h00_01_00_01);
    put(8,  32'h02_02_00_01);
    put(12, 32'h01_03_00_00);
    put(16, 32'h00_F9_00_42);
    release_rst();
    for (int k = 0; k < 5; k++) step();
    check_reg("ovf", 2, 8'h00);
    check_reg("mov", 3, 8'hFF);
    check_reg("dest mask", 1, 8'h42);
    check_reg("ovf src", 0, 8'hFF);

    // Free-running PC sequence over NOPs.
    reset_mid_cycle();
    fill_nop();
    release_rst();
    check("seq pc 0", bus.pc, 32'd0);
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("seq pc %0d", k), bus.pc, 32'(4 * k));
    end
    for (int i = 0; i < 8; i++) check_reg("seq nop", i, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
